// File: rtl/fetch_stage.sv
// Purpose: instruction fetch FSM and IF/ID pipeline register feeding decode/control.
// Latency: one instruction per (imem latency + 1) cycles; IF/ID updates one edge after rvalid.
// Backpressure: stall_if freezes IF/ID; a word that returns during a stall waits in a one-entry skid buffer.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   pc_sel, br_target,
//   jalr_target                next-PC select (0/3 = pc+4, 1 = branch, 2 = jalr) and targets
//   stall_if, flush_if         hold / squash the IF/ID register
//   imem_req, imem_addr        single-outstanding read request, address is the current pc
//   imem_rvalid, imem_rdata    read response
//   instr_decode, pc_decode,
//   valid_decode               IF/ID register contents
module fetch_stage #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR    = 32'h0000_0013,
    parameter int          PC_SEL_WIDTH = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [PC_SEL_WIDTH-1:0] pc_sel,
    input  logic [31:0]             br_target,
    input  logic [31:0]             jalr_target,
    input  logic                    stall_if,
    input  logic                    flush_if,
    output logic                    imem_req,
    output logic [31:0]             imem_addr,
    input  logic                    imem_rvalid,
    input  logic [31:0]             imem_rdata,
    output logic [31:0]             instr_decode,
    output logic [31:0]             pc_decode,
    output logic                    valid_decode
);

    localparam logic [1:0] S_REQ  = 2'd0;  // ready to issue a read at pc
    localparam logic [1:0] S_WAIT = 2'd1;  // one read outstanding, data wanted
    localparam logic [1:0] S_HOLD = 2'd2;  // data captured in skid buffer during a stall
    localparam logic [1:0] S_DROP = 2'd3;  // one read outstanding, data to be discarded

    logic [1:0]  state, state_nxt;
    logic [31:0] pc, pc_nxt, pc_plus4, target;
    logic        redirect;
    logic [31:0] skid_instr, skid_pc;
    logic        skid_load;
    logic        deliver;
    logic [31:0] dlv_instr, dlv_pc;

    assign redirect = (pc_sel == PC_SEL_WIDTH'(1)) || (pc_sel == PC_SEL_WIDTH'(2));
    // Masking rather than slicing keeps every jalr_target bit in use.
    assign target   = (pc_sel == PC_SEL_WIDTH'(1)) ? br_target : (jalr_target & ~32'h1);
    assign pc_plus4 = pc + 32'd4;

    // A redirect suppresses the request so the stale pc is never fetched.
    // rst_n gates the request so nothing is issued while reset is held.
    assign imem_req  = rst_n && (state == S_REQ) && !redirect;
    assign imem_addr = pc;

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        skid_load = 1'b0;
        deliver   = 1'b0;
        dlv_instr = skid_instr;
        dlv_pc    = skid_pc;
        case (state)
            S_REQ: begin
                if (redirect) begin
                    pc_nxt = target;
                end else begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    state_nxt = S_REQ;
                    if (redirect) begin
                        pc_nxt = target;
                    end else if (stall_if) begin
                        skid_load = 1'b1;
                        state_nxt = S_HOLD;
                    end else begin
                        deliver   = 1'b1;
                        dlv_instr = imem_rdata;
                        dlv_pc    = pc;
                        pc_nxt    = pc_plus4;
                    end
                end else if (redirect) begin
                    // The in-flight response belongs to the old path.
                    pc_nxt    = target;
                    state_nxt = S_DROP;
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    pc_nxt    = target;
                    state_nxt = S_REQ;
                end else if (!stall_if) begin
                    deliver   = 1'b1;
                    pc_nxt    = pc_plus4;
                    state_nxt = S_REQ;
                end
            end
            S_DROP: begin
                if (redirect) begin
                    pc_nxt = target;
                end
                if (imem_rvalid) begin
                    state_nxt = S_REQ;
                end
            end
            default: state_nxt = S_REQ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_REQ;
            pc    <= RESET_PC;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
        end
    end

    // Skid buffer occupancy is implied by S_HOLD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_instr <= NOP_INSTR;
            skid_pc    <= RESET_PC;
        end else if (skid_load) begin
            skid_instr <= imem_rdata;
            skid_pc    <= pc;
        end
    end

    // IF/ID: flush > stall > new instruction > bubble. pc_decode is kept on flush/bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_decode <= NOP_INSTR;
            pc_decode    <= RESET_PC;
            valid_decode <= 1'b0;
        end else if (flush_if) begin
            instr_decode <= NOP_INSTR;
            valid_decode <= 1'b0;
        end else if (stall_if) begin
            instr_decode <= instr_decode;
        end else if (deliver) begin
            instr_decode <= dlv_instr;
            pc_decode    <= dlv_pc;
            valid_decode <= 1'b1;
        end else begin
            instr_decode <= NOP_INSTR;
            valid_decode <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Purpose: randomized self-checking bench for fetch_stage against a transaction-level model.
// Latency: memory model answers 1..3 cycles after each accepted request.
// Backpressure: stall_if/flush_if/redirects driven randomly plus directed corner cases.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  pc_sel;
    logic [31:0] br_target, jalr_target;
    logic        stall_if, flush_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instr_decode, pc_decode;
    logic        valid_decode;

    // second instance for the pc wrap case
    logic        w_rst_n;
    logic        w_imem_req;
    logic [31:0] w_imem_addr;
    logic        w_imem_rvalid;
    logic [31:0] w_imem_rdata;
    logic [31:0] w_instr_decode, w_pc_decode;
    logic        w_valid_decode;

    always #5 clk = ~clk;

    fetch_stage u_dut (
        .clk(clk), .rst_n(rst_n), .pc_sel(pc_sel), .br_target(br_target),
        .jalr_target(jalr_target), .stall_if(stall_if), .flush_if(flush_if),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata), .instr_decode(instr_decode), .pc_decode(pc_decode),
        .valid_decode(valid_decode)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk(clk), .rst_n(w_rst_n), .pc_sel(2'd0), .br_target(32'd0),
        .jalr_target(32'd0), .stall_if(1'b0), .flush_if(1'b0),
        .imem_req(w_imem_req), .imem_addr(w_imem_addr), .imem_rvalid(w_imem_rvalid),
        .imem_rdata(w_imem_rdata), .instr_decode(w_instr_decode), .pc_decode(w_pc_decode),
        .valid_decode(w_valid_decode)
    );

    int n_vec  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- memory model ----------------
    logic        mem_busy = 1'b0;
    int          mem_wait = 0;
    logic [31:0] mem_addr = '0;
    int          lat = 1;
    logic        stray = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h0050_0093;
            32'h4:   return 32'h00A0_0113;
            default: return a ^ 32'h5EED_0F13;
        endcase
    endfunction

    // ---------------- reference model ----------------
    // Flags describe what the fetch unit is doing, not how it is encoded.
    logic [31:0] m_pc;
    logic        m_out;      // a wanted read is in flight
    logic        m_drop;     // an unwanted read is in flight
    logic        m_held;     // a fetched word is parked waiting for stall release
    logic [31:0] m_h_i, m_h_p;
    logic [31:0] m_id_i, m_id_p;
    logic        m_id_v;

    task automatic model_reset();
        m_pc = 32'h0; m_out = 0; m_drop = 0; m_held = 0;
        m_h_i = '0; m_h_p = '0;
        m_id_i = NOP; m_id_p = 32'h0; m_id_v = 0;
    endtask

    function automatic logic m_redir();
        return (pc_sel == 2'd1) || (pc_sel == 2'd2);
    endfunction

    task automatic model_step();
        logic        redir, have;
        logic [31:0] tgt, w_i, w_p;
        redir = m_redir();
        tgt   = (pc_sel == 2'd1) ? br_target : {jalr_target[31:1], 1'b0};
        have  = 0; w_i = '0; w_p = '0;
        if (m_drop) begin
            if (redir) m_pc = tgt;
            if (imem_rvalid) m_drop = 0;
        end else if (m_out) begin
            if (imem_rvalid) begin
                m_out = 0;
                if (redir) m_pc = tgt;
                else if (stall_if) begin m_held = 1; m_h_i = imem_rdata; m_h_p = m_pc; end
                else begin have = 1; w_i = imem_rdata; w_p = m_pc; m_pc = m_pc + 32'd4; end
            end else if (redir) begin
                m_out = 0; m_drop = 1; m_pc = tgt;
            end
        end else if (m_held) begin
            if (redir) begin m_held = 0; m_pc = tgt; end
            else if (!stall_if) begin
                have = 1; w_i = m_h_i; w_p = m_h_p; m_held = 0; m_pc = m_pc + 32'd4;
            end
        end else begin
            if (redir) m_pc = tgt;
            else m_out = 1;
        end
        if (flush_if) begin m_id_i = NOP; m_id_v = 0; end
        else if (stall_if) begin end
        else if (have) begin m_id_i = w_i; m_id_p = w_p; m_id_v = 1; end
        else begin m_id_i = NOP; m_id_v = 0; end
    endtask

    // One clock cycle: drive inputs at negedge, check, advance model and memory.
    task automatic cyc(input logic [1:0] sel, input logic [31:0] br, input logic [31:0] jr,
                       input logic st, input logic fl);
        logic exp_req;
        @(negedge clk);
        pc_sel = sel; br_target = br; jalr_target = jr; stall_if = st; flush_if = fl;
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        if (mem_busy) begin
            if (mem_wait == 1) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(mem_addr);
                mem_busy    = 1'b0;
            end else begin
                mem_wait--;
            end
        end
        if (stray) begin
            imem_rvalid = 1'b1;
            stray = 1'b0;
        end
        #1;
        exp_req = !(m_out || m_drop || m_held) && !m_redir();
        chk("imem_req", {31'd0, imem_req}, {31'd0, exp_req});
        chk("imem_addr", imem_addr, m_pc);
        chk("instr_decode", instr_decode, m_id_i);
        chk("pc_decode", pc_decode, m_id_p);
        chk("valid_decode", {31'd0, valid_decode}, {31'd0, m_id_v});
        model_step();
        if (imem_req) begin
            chk("single_outstanding", {31'd0, mem_busy}, 32'd0);
            mem_busy = 1'b1;
            mem_wait = lat;
            mem_addr = imem_addr;
        end
    endtask

    task automatic go_idle();
        for (int i = 0; i < 20; i++) begin
            if (!(m_out || m_drop || m_held)) return;
            cyc(2'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        end
        chk("drain_timeout", 32'd1, 32'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_req"},   {31'd0, imem_req},     32'd0);
        chk({tag, "_addr"},  imem_addr,             32'd0);
        chk({tag, "_instr"}, instr_decode,          NOP);
        chk({tag, "_pc"},    pc_decode,             32'd0);
        chk({tag, "_valid"}, {31'd0, valid_decode}, 32'd0);
    endtask

    initial begin
        rst_n = 0; pc_sel = 0; br_target = 0; jalr_target = 0;
        stall_if = 0; flush_if = 0; imem_rvalid = 0; imem_rdata = 0;
        w_rst_n = 0; w_imem_rvalid = 0; w_imem_rdata = 0;
        model_reset();

        // ---- pc wrap on the RESET_PC = FFFF_FFFC instance ----
        repeat (2) @(negedge clk);
        @(posedge clk); #1 w_rst_n = 1;
        #1;
        chk("wrap_req", {31'd0, w_imem_req}, 32'd1);
        chk("wrap_addr0", w_imem_addr, 32'hFFFF_FFFC);
        @(posedge clk);
        @(negedge clk); w_imem_rvalid = 1; w_imem_rdata = 32'hDEAD_0013;
        @(posedge clk);
        @(negedge clk); w_imem_rvalid = 0; #1;
        chk("wrap_pc_decode", w_pc_decode, 32'hFFFF_FFFC);
        chk("wrap_instr", w_instr_decode, 32'hDEAD_0013);
        chk("wrap_valid", {31'd0, w_valid_decode}, 32'd1);
        chk("wrap_addr1", w_imem_addr, 32'h0);

        // ---- reset values, then 1-cycle memory basic fetch ----
        #1;
        check_reset_vals("rst");
        @(posedge clk); #1 rst_n = 1;
        lat = 1;
        cyc(2'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        cyc(2'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk("first_instr", instr_decode, 32'h0050_0093);
        chk("first_pc", pc_decode, 32'h0);
        chk("first_valid", {31'd0, valid_decode}, 32'd1);
        chk("second_addr", imem_addr, 32'h4);
        chk("second_req", {31'd0, imem_req}, 32'd1);

        // ---- stall for 3 cycles across the rvalid cycle ----
        cyc(2'd0, 32'd0, 32'd0, 1'b1, 1'b0);
        cyc(2'd0, 32'd0, 32'd0, 1'b1, 1'b0);
        cyc(2'd0, 32'd0, 32'd0, 1'b1, 1'b0);
        cyc(2'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk("skid_instr", instr_decode, 32'h00A0_0113);
        chk("skid_pc", pc_decode, 32'h4);
        chk("skid_next_addr", imem_addr, 32'h8);

        // ---- flush and stall together ----
        cyc(2'd0, 32'd0, 32'd0, 1'b1, 1'b1);
        @(posedge clk); #1;
        chk("flush_stall_valid", {31'd0, valid_decode}, 32'd0);
        chk("flush_stall_instr", instr_decode, NOP);

        // ---- redirect while waiting on 3-cycle memory ----
        go_idle();
        lat = 3;
        cyc(2'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        cyc(2'd1, 32'h100, 32'd0, 1'b0, 1'b0);
        cyc(2'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        cyc(2'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk("drop_addr", imem_addr, 32'h100);
        chk("drop_req", {31'd0, imem_req}, 32'd1);
        chk("drop_valid", {31'd0, valid_decode}, 32'd0);

        // ---- jalr target bit 0 cleared ----
        go_idle();
        cyc(2'd2, 32'd0, 32'h203, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk("jalr_addr", imem_addr, 32'h202);

        // ---- reset asserted while waiting ----
        go_idle();
        cyc(2'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        @(negedge clk); pc_sel = 0; #2 rst_n = 0; #1;
        check_reset_vals("midrst");
        model_reset();
        mem_busy = 1'b0;
        imem_rvalid = 1'b1;
        @(posedge clk);
        @(negedge clk); imem_rvalid = 1'b0;
        @(posedge clk); #1 rst_n = 1; #1;
        chk("restart_addr", imem_addr, 32'h0);
        chk("restart_req", {31'd0, imem_req}, 32'd1);
        stray = 1'b1;
        lat = 1;
        repeat (4) cyc(2'd0, 32'd0, 32'd0, 1'b0, 1'b0);

        // ---- randomized traffic ----
        for (int i = 0; i < 3000; i++) begin
            int          r;
            logic [1:0]  s;
            r = $urandom_range(0, 99);
            s = (r < 10) ? 2'd1 : (r < 20) ? 2'd2 : (r < 25) ? 2'd3 : 2'd0;
            lat = $urandom_range(1, 3);
            cyc(s, $urandom, $urandom, ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch stage and IF/ID pipeline register. It is the producer end of the decode/control interface.
- Generates the PC and issues instruction-memory reads over a single-outstanding request/response handshake.
- Delivers instr_decode/pc_decode/valid_decode to decode and control.
- Consumes pc_sel, stall_if and flush_if from control.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- NOP_INSTR, 32'h0000_0013, instruction (addi x0,x0,0) placed in IF/ID on reset, flush and bubble.
- PC_SEL_WIDTH, 2, width of pc_sel.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- pc_sel  in  PC_SEL_WIDTH  0=PC+4, 1=br_target, 2=jalr_target, 3=reserved (treated as 0).
- br_target  in  32  branch/JAL target from decode.
- jalr_target  in  32  JALR target; bit 0 cleared internally.
- stall_if  in  1  hold PC and IF/ID.
- flush_if  in  1  squash IF/ID contents.
- imem_req  out  1  read request; accepted in the cycle it is high.
- imem_addr  out  32  read address, equal to pc.
- imem_rvalid  in  1  read data valid, one or more cycles after the request.
- imem_rdata  in  32  read data.
- instr_decode  out  32  IF/ID instruction.
- pc_decode  out  32  IF/ID PC.
- valid_decode  out  1  IF/ID holds a live instruction.

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC; state=REQ; skid buffer empty.
  - instr_decode=NOP_INSTR, pc_decode=RESET_PC, valid_decode=0.
  - imem_req=0 while in reset.
- Redirect = (pc_sel==1 or pc_sel==2). Target is br_target or {jalr_target[31:1],1'b0}. A redirect always loads pc with the target at the next edge.
- FSM states:
  - REQ: imem_req = !redirect; imem_addr=pc.
    - No redirect: go to WAIT.
    - Redirect: pc<=target, stay in REQ, no request issued.
  - WAIT: one request outstanding.
    - rvalid & redirect: discard the data, pc<=target, go to REQ.
    - rvalid & !stall_if: IF/ID<={rdata,pc,1}, pc<=pc+4, go to REQ.
    - rvalid & stall_if: skid<={rdata,pc}, go to HOLD; IF/ID unchanged.
    - No rvalid & redirect: pc<=target, go to DROP.
    - Otherwise stay in WAIT.
  - HOLD:
    - redirect: empty the skid buffer, pc<=target, go to REQ.
    - !stall_if: IF/ID<={skid,1}, pc<=pc+4, go to REQ.
    - Otherwise stay in HOLD.
  - DROP: wait for rvalid and discard it, then go to REQ.
    - A further redirect while in DROP updates pc and stays in DROP.
- IF/ID update priority, evaluated every edge:
  1. flush_if: instr_decode<=NOP_INSTR, valid_decode<=0. pc_decode is unchanged.
  2. stall_if: hold all IF/ID fields.
  3. New instruction delivered: load it.
  4. Otherwise insert a bubble: instr_decode<=NOP_INSTR, valid_decode<=0, pc_decode held.
- Simultaneous events:
  - flush_if with stall_if: flush wins.
  - Redirect with stall_if: the redirect still updates pc and the FSM; IF/ID follows rules 1–2.
  - Redirect without flush_if is legal: pc redirects, and IF/ID takes a bubble because nothing is delivered that cycle.
- Arithmetic: pc+4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 0. Targets are used unmodified apart from the jalr bit 0 clear.
- Throughput: one instruction per (memory latency + 1) cycles. With 1-cycle memory the sequence is REQ, WAIT, REQ, giving one instruction every 2 cycles.
- At most one request is ever outstanding. imem_req is never high outside REQ.
- Reset asserted mid-transaction returns to the reset values immediately. Any later stray rvalid is ignored until the first REQ after reset.

Test Plan:
- Reset release, 1-cycle memory returning 0x00500093 at 0 and 0x00A00113 at 4:
  - imem_req high in cycle 1 with addr 0x0.
  - instr_decode=0x00500093, pc_decode=0, valid=1 after the rvalid edge.
  - Next request at addr 0x4.
- stall_if held for 3 cycles across the rvalid cycle:
  - IF/ID frozen for those cycles; FSM goes to HOLD.
  - On stall release the buffered word loads with the correct pc; the next request goes to pc+4.
- Redirect while WAIT with 3-cycle memory (pc_sel=1, br_target=0x100):
  - FSM goes to DROP; the late rvalid data is discarded.
  - Next imem_addr=0x100; valid_decode never shows the dropped word.
- flush_if and stall_if asserted together: valid_decode=0 and instr_decode=0x00000013 at the next edge.
- pc_sel=2, jalr_target=0x203: next imem_addr=0x202.
- RESET_PC=32'hFFFF_FFFC, fetch one word: next imem_addr=0x0 (wrap).
- Assert rst_n=0 while WAIT:
  - All outputs return to reset values asynchronously.
  - After release, fetch restarts at RESET_PC.
